// File: rtl/rv32i_types.sv
// ============================================================================
//  Module   : rv32i_types
//  Brief    : Shared fetch-path types: fetch line record, fetch FSM states and
//             the line-formation helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr0;
        logic [XLEN-1:0] instr1;
        logic            num;
    } fetch_line_t;

    // A fetch PC in the upper word of a line yields a single instruction.
    function automatic fetch_line_t form_line(
        input logic [XLEN-1:0]   pc,
        input logic [2*XLEN-1:0] rdata
    );
        fetch_line_t line;
        line.pc = pc;
        if (pc[2]) begin
            line.instr0 = rdata[2*XLEN-1:XLEN];
            line.instr1 = '0;
            line.num    = 1'b0;
        end else begin
            line.instr0 = rdata[XLEN-1:0];
            line.instr1 = rdata[2*XLEN-1:XLEN];
            line.num    = 1'b1;
        end
        return line;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_line_fifo.sv
// ============================================================================
//  Module   : fetch_line_fifo
//  Brief    : Power-of-two deep FIFO of fetch lines with synchronous flush.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_line_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  fetch_line_t                i_wr_line,
    input  logic                       i_rd_en,
    output fetch_line_t                o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    fetch_line_t        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_rd;
    logic               w_do_wr;

    assign w_do_rd = i_rd_en && (r_count != '0);
    // A full FIFO still accepts a write when the head leaves the same cycle.
    assign w_do_wr = i_wr_en && ((r_count != c_depth_cnt) || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_line_buffer.sv
// ============================================================================
//  Module   : fetch_line_buffer
//  Brief    : Fetch PC owner, 64-bit line read handshake and line buffer
//             feeding decode. Optional FETCH_BYPASS_EN presents a response
//             combinationally when the buffer is empty.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_line_buffer
    import rv32i_types::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0060
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [WIDTH-1:0]   redirect_pc,
    input  logic               i_mem_resp,
    input  logic [2*WIDTH-1:0] i_mem_rdata,
    output logic               i_mem_read,
    output logic [WIDTH-1:0]   i_mem_address,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_pc,
    output logic [WIDTH-1:0]   out_instr0,
    output logic [WIDTH-1:0]   out_instr1,
    output logic               out_num,
    input  logic               deq
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [WIDTH-1:0]   c_line_bytes = WIDTH'(8);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [WIDTH-1:0]   r_fetch_pc;
    logic [WIDTH-1:0]   r_req_addr;
    logic [WIDTH-1:0]   w_line_addr;
    fetch_line_t        w_resp_line;
    fetch_line_t        w_head_line;
    fetch_line_t        w_out_line;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_empty;
    logic               w_issue;
    logic               w_resp_live;
    logic               w_bypass;
    logic               w_fifo_wr;
    logic               w_fifo_rd;
    logic               w_unused;

    assign w_unused    = ^redirect_pc[1:0];
    assign w_line_addr = {r_fetch_pc[WIDTH-1:3], 3'b000};
    assign w_resp_line = form_line(r_fetch_pc, i_mem_rdata);
    // Only a response to a request that is still current produces a line.
    assign w_resp_live = (r_state == WAIT) && i_mem_resp && !redirect;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst && !redirect && (w_fifo_count < c_depth_cnt)) begin
                    w_issue      = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (i_mem_resp) begin
                    w_next_state = IDLE;
                end else if (redirect) begin
                    w_next_state = DROP;
                end
            end
            DROP: begin
                if (i_mem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_req_addr <= w_line_addr;
            end
            if (redirect) begin
                r_fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
            end else if (w_resp_live) begin
                r_fetch_pc <= w_line_addr + c_line_bytes;
            end
        end
    end

    // The request address is held from the issuing cycle until the response,
    // even after a redirect has already moved the fetch PC.
    always_comb begin
        i_mem_read    = 1'b0;
        i_mem_address = '0;
        if (w_issue) begin
            i_mem_read    = 1'b1;
            i_mem_address = w_line_addr;
        end else if (r_state != IDLE) begin
            i_mem_read    = 1'b1;
            i_mem_address = r_req_addr;
        end
    end

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_resp_live && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_wr = w_resp_live && !(w_bypass && deq);
    assign w_fifo_rd = deq && !w_fifo_empty && !redirect;

    fetch_line_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (redirect),
        .i_wr_en   (w_fifo_wr),
        .i_wr_line (w_resp_line),
        .i_rd_en   (w_fifo_rd),
        .o_head    (w_head_line),
        .o_count   (w_fifo_count),
        .o_empty   (w_fifo_empty)
    );

    assign w_out_line = w_bypass ? w_resp_line : w_head_line;
    assign out_valid  = !w_fifo_empty || w_bypass;

    always_comb begin
        out_pc     = '0;
        out_instr0 = '0;
        out_instr1 = '0;
        out_num    = 1'b0;
        if (out_valid) begin
            out_pc     = w_out_line.pc;
            out_instr0 = w_out_line.instr0;
            out_instr1 = w_out_line.instr1;
            out_num    = w_out_line.num;
        end
    end

endmodule

`default_nettype wire

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Instruction-fetch front stage between the I-side memory port and the two decoders/instruction queue. Owns the fetch PC, issues 64-bit aligned line reads, buffers returned lines with their PC and valid-slot count, and presents one line (one or two instructions) per cycle to the decode/enqueue logic. Handles redirects (branch mispredict flush, predicted-taken jumps) by discarding buffered lines and any in-flight response.

## Interface
Parameters:
- width, 32, instruction/address width
- depth, 4, line FIFO entries (power of two, ≥2)
- reset_pc, 32'h0000_0060, fetch PC after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect  in  1  discard buffered/in-flight lines, restart fetch at redirect_pc
- redirect_pc  in  width  new fetch PC (bits [1:0] ignored)
- i_mem_resp  in  1  line read complete
- i_mem_rdata  in  2*width  line data; [31:0] at addr, [63:32] at addr+4
- i_mem_read  out  1  read request, held until i_mem_resp
- i_mem_address  out  width  line address, bits [2:0] = 0
- out_valid  out  1  head line available
- out_pc  out  width  PC of first valid instruction in head line
- out_instr0  out  width  instruction at out_pc
- out_instr1  out  width  instruction at out_pc+4 (valid only when out_num=1)
- out_num  out  1  0 = one instruction, 1 = two (matches num_fetch usage)
- deq  in  1  consumer takes head line; ignored when out_valid=0

## Operation
- Registers: fetch_pc, FIFO (pc, 64-bit data, num), head/tail pointers, count, FSM.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if count + 0 < depth and no redirect → assert i_mem_read, i_mem_address = {fetch_pc[31:3],3'b0}, go WAIT.
  - WAIT: hold request. On i_mem_resp: write entry, advance fetch_pc = {fetch_pc[31:3],3'b0}+8, go IDLE.
  - DROP: in-flight response owed to stale PC; hold i_mem_read/address; on i_mem_resp discard data, go IDLE.
- Entry formation: fetch_pc[2]=0 → pc=fetch_pc, instr0=rdata[31:0], instr1=rdata[63:32], num=1. fetch_pc[2]=1 → pc=fetch_pc, instr0=rdata[63:32], num=0, instr1=0.
- Request only if (count < depth) counting the outstanding line as occupied; no request in the cycle a redirect is asserted.
- Redirect (any state): count←0, head=tail; fetch_pc←{redirect_pc[31:2],2'b0}. From WAIT → DROP (unless i_mem_resp same cycle: data discarded, go IDLE). From IDLE/DROP → IDLE/DROP unchanged. Redirect beats deq and resp writes.
- Simultaneous deq and write with count=depth-1 or full: both occur, count unchanged.
- Pointers wrap modulo depth.

## Timing
- Reset values: i_mem_read=0, i_mem_address=0, out_valid=0, out_pc=0, out_instr0/1=0, out_num=0; fetch_pc=reset_pc, FSM=IDLE, count=0.
- First request: cycle after rst deasserts.
- Response → out_valid: 1 cycle (entry registered), unless bypass configured.
- Back-to-back: new request issued in cycle after resp (IDLE one cycle); steady state one line per (memory latency + 1) cycles.
- Outputs driven from FIFO head; deq advances head at clock edge, next entry visible next cycle.
- Redirect: out_valid=0 the cycle after; first new request issued the cycle after redirect (IDLE) or after stale resp (DROP).

## Configuration
- FETCH_BYPASS_EN defined: when FIFO empty (count=0) and i_mem_resp in WAIT, the formed entry is driven on out_* combinationally with out_valid=1 that cycle; if deq same cycle, entry not written. Without it: always write then present next cycle. Redirect and DROP suppress bypass in both cases.

## Structure
- Shared package (rv32i_types): fetch_line_t {pc, instr0, instr1, num}, fetch_state_t enum {IDLE, WAIT, DROP}.
- One sub-module: fetch_line_fifo (depth-parameterised storage, pointers, count, flush input); FSM, PC and memory handshake stay in the top.

## Test plan
- Reset, reset_pc=0x60, resp after 2 cycles with rdata=0x00200093_00100093 → out_pc=0x60, instr0=0x00100093, instr1=0x00200093, out_num=1; next request address 0x68.
- redirect_pc=0x104 → request addr 0x100; rdata upper=0xDEADBEEF → out_pc=0x104, instr0=0xDEADBEEF, out_num=0; next address 0x108.
- No deq, depth=4: exactly 4 requests issued, i_mem_read stays 0 afterwards; one deq → fifth request next cycle.
- Redirect to 0x200 during WAIT for 0x80: stale resp dropped (no out_valid), next request 0x200, first out_pc=0x200.
- Redirect, deq and i_mem_resp in the same cycle with 2 entries → count=0, out_valid=0 next cycle, request 0x<redirect> issued.
- FETCH_BYPASS_EN, empty FIFO: resp cycle shows out_valid=1 with resp data; with deq asserted, count stays 0.
